// File: rtl/dmemory_ctrl_pkg.sv
// Shared definitions for the byte-addressed data memory controller.
// Size codes, FSM states and lane helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } state_t;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        unique case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Lane-0 byte-enable pattern for the given size.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        unique case (size)
            SIZE_B:  m = 4'b0001;
            SIZE_H:  m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmemory_ctrl_if.sv
// Request/response bus of the data memory controller.
// master = load/store unit, slave = memory.
interface dmemory_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;

    modport master (
        output req_valid,
        output req_write,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_error
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_error
    );

endinterface

// File: rtl/dmemory_ctrl_bank.sv
// Word-wide storage array with per-byte write enables.
// Read data is registered; contents are never reset.
module mem_bank #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string MEM_PATH    = "",
  localparam int   IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clock,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we[0]) mem[addr][7:0]   <= wdata[7:0];
      if (we[1]) mem[addr][15:8]  <= wdata[15:8];
      if (we[2]) mem[addr][23:16] <= wdata[23:16];
      if (we[3]) mem[addr][31:24] <= wdata[31:24];
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmemory_ctrl.sv
// Byte-addressed RV32 memory controller: sizes, extension,
// two-beat split accesses and range checking.
module dmemory_ctrl
    import mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DEFAULT_BASE_ADDR),
    parameter string                 MEM_PATH    = ""
) (
    input logic           clock,
    input logic           reset_n,
    dmemory_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES =
        (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    state_t state;
    logic   ready_q;
    logic   valid_q;
    logic   error_q;

    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           beat0_q;

    logic                  accept;
    logic [2:0]            nbytes;
    logic [ADDR_WIDTH:0]   offset_x;
    logic [ADDR_WIDTH:0]   end_x;
    logic                  err;
    logic [1:0]            lane;
    logic [IDX_W-1:0]      word;
    logic [IDX_W-1:0]      word_next;
    logic                  split;
    logic [7:0]            mask8;
    logic [63:0]           wide_w;
    logic [31:0]           rot_w;
    logic [63:0]           pair;
    logic [31:0]           shifted;
    logic [31:0]           load_val;

    logic                  bank_en;
    logic [3:0]            bank_we;
    logic [IDX_W-1:0]      bank_addr;
    logic [31:0]           bank_rdata;

    assign accept = bus.req_valid && ready_q;

    // Decode of the captured request; all checks run on registered values.
    assign nbytes    = size_bytes(r_size);
    assign offset_x  = {1'b0, r_addr} - {1'b0, BASE_ADDR};
    assign end_x     = offset_x + (ADDR_WIDTH+1)'(nbytes);
    assign err       = (r_addr < BASE_ADDR) || (r_size == 2'd3) ||
                       (end_x > MEM_BYTES);
    assign lane      = offset_x[1:0];
    assign word      = offset_x[IDX_W+1:2];
    assign word_next = word + 1'b1;
    assign split     = !err && (({1'b0, lane} + nbytes) > 3'd4);

    // Store data and enables span two words; each beat takes its half.
    assign mask8  = {4'b0000, size_mask(r_size)} << lane;
    assign wide_w = {32'b0, r_wdata} << {lane, 3'b000};
    assign rot_w  = wide_w[31:0] | wide_w[63:32];

    // Load assembly: beat 0 sits low, beat 1 high, then shift by lane.
    assign pair    = split ? {bank_rdata, beat0_q} : {32'b0, bank_rdata};
    assign shifted = 32'(pair >> {lane, 3'b000});

    // Sign or zero extension of sub-word loads.
    always_comb begin
        load_val = shifted;
        unique case (r_size)
            SIZE_B:  load_val = {{24{~r_unsigned & shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_val = {{16{~r_unsigned & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    // Array port steering: word w in ACCESS, word w+1 in SPLIT.
    always_comb begin
        bank_en   = 1'b0;
        bank_we   = 4'b0000;
        bank_addr = word;
        unique case (state)
            ACCESS: begin
                bank_en = !err;
                bank_we = (r_write && !err) ? mask8[3:0] : 4'b0000;
            end
            SPLIT: begin
                bank_en   = 1'b1;
                bank_addr = word_next;
                bank_we   = r_write ? mask8[7:4] : 4'b0000;
            end
            default: ;
        endcase
    end

    mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .MEM_PATH    (MEM_PATH)
    ) u_bank (
        .clock (clock),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (rot_w),
        .rdata (bank_rdata)
    );

    // Request FSM with registered handshake outputs and request capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            beat0_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state      <= ACCESS;
                        ready_q    <= 1'b0;
                        r_write    <= bus.req_write;
                        r_size     <= bus.req_size;
                        r_unsigned <= bus.req_unsigned;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (split) begin
                        state <= SPLIT;
                    end else begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                        error_q <= err;
                    end
                end
                SPLIT: begin
                    state   <= RESP;
                    ready_q <= 1'b1;
                    valid_q <= 1'b1;
                    beat0_q <= bank_rdata;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_error = error_q;
    assign bus.resp_rdata = (valid_q && !error_q && !r_write) ? load_val : 32'h0;

endmodule

// File: tb/tb_dmemory_ctrl.sv
// Scoreboard bench for dmemory_ctrl against a byte-array reference.
// Directed scenarios followed by randomized traffic.
module tb_dmemory_ctrl;
    import mem_pkg::*;

    localparam logic [31:0] BASE      = 32'h0100_0000;
    localparam int          MEM_BYTES = 4096;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          at;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] mem_m [MEM_BYTES];

    dmemory_ctrl_if #(.ADDR_WIDTH(32)) rq();

    dmemory_ctrl #(
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (BASE),
        .MEM_PATH    ("")
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (rq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: byte-level little-endian memory, computed per access.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er,
                         output int lat);
        int     n;
        longint off;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = longint'(a) - longint'(BASE);
        er  = (sz == 2'd3) || (off < 0) || (off + n > MEM_BYTES);
        rd  = 32'h0;
        lat = 2;
        if (!er) begin
            if ((off % 4) + n > 4) lat = 3;
            for (int i = 0; i < n; i++) begin
                if (w) mem_m[int'(off) + i] = d[8*i +: 8];
                else   rd[8*i +: 8] = mem_m[int'(off) + i];
            end
            if (!w && !u && n < 4 && rd[8*n-1])
                rd = rd | ~((32'h1 << (8*n)) - 32'h1);
        end
    endtask

    // Present a request from a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit track, output int acc);
        int          n;
        exp_t        e;
        logic [31:0] rd;
        logic        er;
        int          lat;
        n               = 0;
        rq.req_valid    = 1'b1;
        rq.req_write    = w;
        rq.req_size     = sz;
        rq.req_unsigned = u;
        rq.req_addr     = a;
        rq.req_wdata    = d;
        while (!rq.req_ready && n < 16) begin
            @(negedge clock);
            n++;
        end
        acc = cyc + 1;
        check("req_ready_within_bound", 32'(rq.req_ready), 32'h1);
        if (track && rq.req_ready) begin
            model(w, sz, u, a, d, rd, er, lat);
            e.rdata = rd;
            e.err   = er;
            e.at    = acc + lat - 1;
            exp_q.push_back(e);
        end
        @(negedge clock);
        rq.req_wdata = $urandom;
        rq.req_addr  = $urandom;
    endtask

    task automatic idle(input int k);
        rq.req_valid = 1'b0;
        repeat (k) @(negedge clock);
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && rq.resp_valid) begin
            check("resp_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("resp_rdata", rq.resp_rdata, mon_e.rdata);
                check("resp_error", 32'(rq.resp_error), 32'(mon_e.err));
                check("resp_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        int          acc;
        int          prev;
        logic        w;
        logic        u;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        rq.req_valid    = 1'b0;
        rq.req_write    = 1'b0;
        rq.req_size     = SIZE_W;
        rq.req_unsigned = 1'b0;
        rq.req_addr     = BASE;
        rq.req_wdata    = 32'h0;

        #2 reset_n = 1'b0;
        #1;
        check("reset_req_ready", 32'(rq.req_ready), 32'h1);
        check("reset_resp_valid", 32'(rq.resp_valid), 32'h0);
        check("reset_resp_rdata", rq.resp_rdata, 32'h0);
        check("reset_resp_error", 32'(rq.resp_error), 32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 1024; i++)
            issue(1'b1, SIZE_W, 1'b0, BASE + 32'(4*i), $urandom, 1'b1, acc);
        idle(3);

        issue(1'b1, SIZE_W, 1'b0, BASE, 32'hDEAD_BEEF, 1'b1, acc);
        issue(1'b0, SIZE_W, 1'b0, BASE, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_B, 1'b0, BASE + 32'd3, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_B, 1'b1, BASE + 32'd3, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_H, 1'b1, BASE + 32'd2, 32'h0, 1'b1, acc);
        idle(2);

        issue(1'b1, SIZE_W, 1'b0, BASE + 32'd6, 32'h1122_3344, 1'b1, acc);
        issue(1'b0, SIZE_W, 1'b0, BASE + 32'd6, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_H, 1'b1, BASE + 32'd4, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_H, 1'b1, BASE + 32'd10, 32'h0, 1'b1, acc);
        idle(3);

        issue(1'b0, SIZE_W, 1'b0, 32'h00FF_FFFC, 32'h0, 1'b1, acc);
        issue(1'b1, SIZE_W, 1'b0, 32'h0100_0FFE, 32'h5555_AAAA, 1'b1, acc);
        issue(1'b0, SIZE_W, 1'b0, 32'h0100_0FFC, 32'h0, 1'b1, acc);
        issue(1'b1, 2'd3, 1'b0, BASE, 32'h1234_5678, 1'b1, acc);
        issue(1'b0, SIZE_W, 1'b0, BASE, 32'h0, 1'b1, acc);
        idle(3);

        issue(1'b0, SIZE_W, 1'b0, BASE + 32'h40, 32'h0, 1'b1, prev);
        for (int i = 1; i < 4; i++) begin
            issue(1'b0, SIZE_W, 1'b0, BASE + 32'h40 + 32'(4*i), 32'h0, 1'b1, acc);
            check("b2b_accept_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end
        idle(4);

        issue(1'b1, SIZE_W, 1'b0, BASE + 32'd2, 32'hAABB_CCDD, 1'b0, acc);
        rq.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        mem_m[2] = 8'hDD;
        mem_m[3] = 8'hCC;
        #1;
        check("midreset_req_ready", 32'(rq.req_ready), 32'h1);
        check("midreset_resp_valid", 32'(rq.resp_valid), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(3);
        issue(1'b0, SIZE_W, 1'b0, BASE, 32'h0, 1'b1, acc);
        issue(1'b0, SIZE_W, 1'b0, BASE + 32'd4, 32'h0, 1'b1, acc);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'($urandom_range(1, 8));
            else if (r == 1) a = BASE + 32'(MEM_BYTES) - 32'($urandom_range(0, 4));
            else             a = BASE + 32'($urandom_range(0, MEM_BYTES - 1));
            issue(w, sz, u, a, $urandom, 1'b1, acc);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(10);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
